// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Data-memory access stage of the single-issue RISC-V core. A memory
// instruction from the decoder/ALU is captured, issued as a single
// transaction on a valid/ready data bus, and the core is stalled until it
// completes. Loads return a lane-aligned, sign- or zero-extended value.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   req_valid                memory instruction present this cycle
//   memRW                    1 = store, 0 = load
//   loadsize                 load funct3 (lb/lh/lw/lbu/lhu, others act as lw)
//   storesize                sb/sh/sw (3 acts as sw)
//   addr, wdata              ALU byte address, rs2 store data
//   stall                    hold PC and pipeline inputs
//   rdata, rdata_valid       extended load result and writeback strobe
//   bus_err                  access aborted after TIMEOUT_CYCLES
//   bus_valid, bus_we        request valid / request is write
//   bus_addr, bus_be         word address and byte enables
//   bus_wdata                lane-replicated store data
//   bus_ready                request accepted
//   bus_rdata, bus_rvalid    read word and its valid
//   misalign                 (LSU_MISALIGN_TRAP_EN only) misaligned access
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, a misaligned halfword/word issues no
//                         bus transaction and reports misalign in DONE.
//                         When undefined, low address bits are ignored.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        memRW,
    input  logic [2:0]  loadsize,
    input  logic [1:0]  storesize,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              cap_we;
    logic [2:0]        cap_loadsize;
    logic [1:0]        cap_lane;
    logic [31:0]       bus_addr_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       bus_wdata_q;
    logic [TO_W-1:0]   to_cnt;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              mis_q;

    logic              capture_data;
    logic              abort;
    logic              trap;
    logic              timed_out;

    // Byte enables for the captured request; loads always read the whole word.
    function automatic logic [3:0] format_be(input logic we, input logic [1:0] ss,
                                             input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b1111;
        if (we) begin
            case (ss)
                2'd0:    be = 4'b0001 << lane;
                2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Store data is replicated across lanes so the enabled lane always
    // carries the right bytes regardless of address.
    function automatic logic [31:0] format_wdata(input logic we, input logic [1:0] ss,
                                                 input logic [31:0] d);
        logic [31:0] w;
        w = 32'd0;
        if (we) begin
            case (ss)
                2'd0:    w = {4{d[7:0]}};
                2'd1:    w = {2{d[15:0]}};
                default: w = d;
            endcase
        end
        return w;
    endfunction

    // Pick the addressed byte/half from the read word and extend it.
    function automatic logic [31:0] extract_load(input logic [2:0] ls, input logic [1:0] lane,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (ls)
            3'd0:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'd0, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd5:    r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic we, input logic [2:0] ls,
                                           input logic [1:0] ss, input logic [1:0] lane);
        logic half;
        logic word;
        if (we) begin
            half = (ss == 2'd1);
            word = (ss[1] == 1'b1);
        end else begin
            half = (ls == 3'd1) || (ls == 3'd5);
            word = !(half || (ls == 3'd0) || (ls == 3'd4));
        end
        return (half && lane[0]) || (word && (lane != 2'd0));
    endfunction
`endif

    // The counter counts cycles already spent in REQ/WAIT, so this cycle is
    // the last one allowed before the access is abandoned.
    assign timed_out = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic. Completion wins over timeout in the final allowed
    // cycle, and timeout wins over the REQ->WAIT move.
    always_comb begin
        next_state   = state;
        capture_data = 1'b0;
        abort        = 1'b0;
        trap         = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(memRW, loadsize, storesize, addr[1:0])) begin
                        next_state = S_DONE;
                        trap       = 1'b1;
                    end else begin
                        next_state = S_REQ;
                    end
`else
                    next_state = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (bus_ready && (cap_we || bus_rvalid)) begin
                    next_state   = S_DONE;
                    capture_data = !cap_we;
                end else if (timed_out) begin
                    next_state = S_DONE;
                    abort      = 1'b1;
                end else if (bus_ready) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    next_state   = S_DONE;
                    capture_data = 1'b1;
                end else if (timed_out) begin
                    next_state = S_DONE;
                    abort      = 1'b1;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State, captured request, timeout counter and load result.
    // err_q/mis_q are set only on the edge into DONE, so they are high for
    // exactly the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cap_we       <= 1'b0;
            cap_loadsize <= 3'd0;
            cap_lane     <= 2'd0;
            bus_addr_q   <= 32'd0;
            bus_be_q     <= 4'd0;
            bus_wdata_q  <= 32'd0;
            to_cnt       <= '0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= abort;
            mis_q <= trap;
            if (state == S_IDLE) begin
                to_cnt <= '0;
                if (req_valid) begin
                    cap_we       <= memRW;
                    cap_loadsize <= loadsize;
                    cap_lane     <= addr[1:0];
                    bus_addr_q   <= {addr[31:2], 2'b00};
                    bus_be_q     <= format_be(memRW, storesize, addr[1:0]);
                    bus_wdata_q  <= format_wdata(memRW, storesize, wdata);
                end
            end else if ((state == S_REQ) || (state == S_WAIT)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (capture_data) begin
                rdata_q <= extract_load(cap_loadsize, cap_lane, bus_rdata);
            end else if (abort || trap) begin
                rdata_q <= 32'd0;
            end
        end
    end

    // In IDLE the stall follows req_valid directly so the core freezes its
    // operands in the same cycle the request is captured.
    always_comb begin
        stall       = 1'b0;
        case (state)
            S_IDLE:         stall = req_valid;
            S_REQ, S_WAIT:  stall = 1'b1;
            default:        stall = 1'b0;
        endcase
        bus_valid   = (state == S_REQ);
        bus_we      = (state == S_REQ) && cap_we;
        rdata_valid = (state == S_DONE) && !cap_we && !err_q && !mis_q;
    end

    assign rdata     = rdata_q;
    assign bus_err   = err_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign  = mis_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives scripted bus handshakes around each memory instruction and compares
// every cycle against a transaction-level reference model (byte arithmetic on
// the address and data, timing computed from ready/rvalid delays).
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        memRW;
    logic [2:0]  loadsize;
    logic [1:0]  storesize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .memRW       (memRW),
        .loadsize    (loadsize),
        .storesize   (storesize),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .bus_err     (bus_err),
        .bus_valid   (bus_valid),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata),
        .bus_rvalid  (bus_rvalid)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign    (misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Access width in bytes as the instruction asks for it.
    function automatic int sizeBytes(input logic we, input logic [2:0] ls, input logic [1:0] ss);
        if (we) return (ss == 0) ? 1 : (ss == 1) ? 2 : 4;
        if (ls == 0 || ls == 4) return 1;
        if (ls == 1 || ls == 5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] expBe(input logic we, input int n, input logic [31:0] a);
        if (!we || n == 4) return 32'd15;
        if (n == 1) return 32'd1 << (a % 4);
        return 32'd3 << (a & 32'd2);
    endfunction

    function automatic logic [31:0] expWdata(input int n, input logic [31:0] d);
        if (n == 1) return (d & 32'hFF) * 32'h01010101;
        if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] ls, input int n,
                                            input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int          offset;
        offset = (n == 1) ? int'(a % 4) : (n == 2) ? int'((a % 4) / 2 * 2) : 0;
        v = w >> (8 * offset);
        if (n == 1) begin
            v = v & 32'hFF;
            if (ls < 4 && v >= 128) v = v - 32'd256;
        end else if (n == 2) begin
            v = v & 32'hFFFF;
            if (ls < 4 && v >= 32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic isMisaligned(input int n, input logic [31:0] a);
        return (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
    endfunction

    // One instruction: IDLE request cycle, rdel cycles until bus_ready, then
    // vdel more cycles until bus_rvalid (loads), DONE, and a quiet IDLE cycle.
    task automatic applyStimulus(input logic we, input logic [2:0] ls, input logic [1:0] ss,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input int rdel, input int vdel, input logic [31:0] rword);
        int   n;
        int   kdone;
        int   len;
        logic aborted;
        logic trap;
        n       = sizeBytes(we, ls, ss);
        trap    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap    = isMisaligned(n, a);
`endif
        kdone   = we ? rdel : rdel + vdel;
        aborted = !trap && (kdone >= T);
        len     = trap ? 0 : (aborted ? T : kdone + 1);

        @(negedge clk);
        req_valid  = 1'b1;
        memRW      = we;
        loadsize   = ls;
        storesize  = ss;
        addr       = a;
        wdata      = d;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = $urandom;
        #1;
        checkOutput("stall_req", stall, 1);
        checkOutput("bus_valid_idle", bus_valid, 0);

        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            bus_ready  = (k == rdel);
            bus_rvalid = !we && (k == rdel + vdel);
            bus_rdata  = (k == rdel + vdel) ? rword : $urandom;
            #1;
            checkOutput("stall_busy", stall, 1);
            checkOutput("bus_valid", bus_valid, (k <= rdel));
            if (k <= rdel) begin
                checkOutput("bus_addr", bus_addr, a & ~32'd3);
                checkOutput("bus_we", bus_we, we);
                checkOutput("bus_be", bus_be, expBe(we, n, a));
                if (we) checkOutput("bus_wdata", bus_wdata, expWdata(n, d));
            end
        end

        @(negedge clk);
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = $urandom;
        #1;
        checkOutput("stall_done", stall, 0);
        checkOutput("bus_valid_done", bus_valid, 0);
        checkOutput("bus_err", bus_err, aborted);
        if (!aborted) checkOutput("rdata_valid", rdata_valid, !we && !trap);
        if (!we && !aborted && !trap) checkOutput("rdata", rdata, expLoad(ls, n, a, rword));
        if (aborted || trap) checkOutput("rdata_zero", rdata, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("misalign", misalign, trap);
`endif

        @(negedge clk);
        req_valid  = 1'b0;
        bus_rvalid = 1'($urandom_range(0, 1));
        #1;
        checkOutput("stall_after", stall, 0);
        checkOutput("bus_valid_after", bus_valid, 0);
        checkOutput("rdata_valid_after", rdata_valid, 0);
        checkOutput("bus_err_after", bus_err, 0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        memRW      = 1'b0;
        loadsize   = 3'd0;
        storesize  = 2'd0;
        addr       = 32'd0;
        wdata      = 32'd0;
        bus_ready  = 1'b0;
        bus_rdata  = 32'd0;
        bus_rvalid = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_rdata_valid", rdata_valid, 0);
        checkOutput("rst_bus_err", bus_err, 0);
        checkOutput("rst_bus_valid", bus_valid, 0);
        checkOutput("rst_bus_we", bus_we, 0);
        checkOutput("rst_bus_addr", bus_addr, 0);
        checkOutput("rst_bus_be", bus_be, 0);
        checkOutput("rst_bus_wdata", bus_wdata, 0);
        checkOutput("rst_rdata", rdata, 0);
        rst = 1'b0;

        // Directed cases
        applyStimulus(1'b1, 3'd0, 2'd0, 32'h1003, 32'h000000A5, 0, 0, 32'd0);
        applyStimulus(1'b0, 3'd0, 2'd0, 32'h2002, 32'h0, 0, 0, 32'h00800000);
        applyStimulus(1'b0, 3'd4, 2'd0, 32'h2002, 32'h0, 0, 0, 32'h00800000);
        applyStimulus(1'b0, 3'd5, 2'd0, 32'h2002, 32'h0, 0, 3, 32'hBEEF1234);
        applyStimulus(1'b0, 3'd2, 2'd0, 32'h2000, 32'h0, 1000, 0, 32'h12345678);
        applyStimulus(1'b0, 3'd2, 2'd0, 32'h2004, 32'h0, 1, 3, 32'h12345678);
        applyStimulus(1'b1, 3'd0, 2'd2, 32'h3002, 32'hCAFEF00D, 1, 0, 32'd0);
        applyStimulus(1'b1, 3'd0, 2'd1, 32'h3006, 32'h00001234, 2, 0, 32'd0);

        // Reset while waiting for read data; a late rvalid must be ignored.
        @(negedge clk);
        req_valid = 1'b1; memRW = 1'b0; loadsize = 3'd2; addr = 32'h4000;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0; rst = 1'b1;
        #1;
        checkOutput("wait_stall", stall, 1);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
        #1;
        checkOutput("rst_mid_stall", stall, 0);
        checkOutput("rst_mid_bus_valid", bus_valid, 0);
        checkOutput("rst_mid_rdata_valid", rdata_valid, 0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        checkOutput("late_rvalid_rdata_valid", rdata_valid, 0);
        checkOutput("late_rvalid_rdata", rdata, 0);
        checkOutput("late_rvalid_stall", stall, 0);

        // Randomised instructions and bus timing
        for (int i = 0; i < 150; i++) begin
            int rdel;
            rdel = ($urandom_range(0, 15) == 0) ? 1000 : int'($urandom_range(0, 4));
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)), $urandom, $urandom,
                          rdel, int'($urandom_range(0, 3)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
